traffic_phase_ctrl: RTL and testbench

// - Sequences the main/side traffic lights and pedestrian walk phase of the intersection.
// - Consumes the latched walk request (wr) from walk_register.
// - Returns a one-cycle wr_reset when the walk phase is granted.
// - Arbitrates between side-street sensor demand and walk demand; main street green is the rest state.

---
 rtl/tpc_pkg.sv | 32 +++
 rtl/tpc_phase_timer.sv | 40 ++++
 rtl/traffic_phase_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_pkg.sv
// Shared constants for the intersection phase controller.
// State codes, lamp codes and the phase-timer width helper.
package tpc_pkg;

    typedef logic [2:0] tpc_state_t;

    localparam logic [2:0] ST_MAIN_G = 3'd0;
    localparam logic [2:0] ST_MAIN_Y = 3'd1;
    localparam logic [2:0] ST_RED_M  = 3'd2;
    localparam logic [2:0] ST_WALK   = 3'd3;
    localparam logic [2:0] ST_SIDE_G = 3'd4;
    localparam logic [2:0] ST_SIDE_Y = 3'd5;
    localparam logic [2:0] ST_RED_S  = 3'd6;
    localparam logic [2:0] ST_NIGHT  = 3'd7;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    // Bits needed to hold the longest phase length in ticks.
    function automatic int tpc_timer_w(input int a, input int b,
                                       input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tpc_phase_timer.sv
// Phase timer: clock prescaler feeding a tick-driven down-counter.
// A load restarts both the prescaler and the phase length.
module tpc_phase_timer #(
    parameter int CLK_DIV = 4,
    parameter int TW      = 3,
    parameter int RST_VAL = 6
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          tick_o,
    output logic          expire_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [TW-1:0] timer_q;

    assign tick_o   = (presc_q == PW'(CLK_DIV - 1));
    assign expire_o = tick_o && (timer_q == TW'(1));

    // Prescaler wraps on tick; counter decrements once per tick.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
            timer_q <= TW'(RST_VAL);
        end else if (load_i) begin
            presc_q <= '0;
            timer_q <= load_val_i;
        end else if (tick_o) begin
            presc_q <= '0;
            if (timer_q != '0) timer_q <= timer_q - TW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Main/side/walk phase sequencer; main green is the rest state.
// Optional night flash mode is enabled by defining TPC_NIGHT_FLASH_EN.
module traffic_phase_ctrl
    import tpc_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int T_BASE  = 6,
    parameter int T_EXT   = 3,
    parameter int T_YEL   = 2,
    parameter int T_WALK  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       wr,
`ifdef TPC_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       wr_reset
);

    localparam int TW = tpc_timer_w(T_BASE, T_EXT, T_YEL, T_WALK);

    tpc_state_t    state_q, state_d;
    tpc_state_t    prev_q;
    logic          ext_q, ext_d;
    logic          load;
    logic [TW-1:0] load_val;
    logic          tick;
    logic          expire;
    logic [2:0]    main_q, main_d;
    logic [2:0]    side_q, side_d;
    logic          walk_q, wrr_q;
`ifdef TPC_NIGHT_FLASH_EN
    logic          flash_q;
`endif

    tpc_phase_timer #(
        .CLK_DIV (CLK_DIV),
        .TW      (TW),
        .RST_VAL (T_BASE)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_o     (tick),
        .expire_o   (expire)
    );

    // Next phase; demand inputs are only looked at on expiry.
    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        load     = 1'b0;
        load_val = TW'(T_BASE);
        if (tick) begin
            case (state_q)
                ST_MAIN_G: if (expire) begin
                    load = 1'b1;
                    if (wr || sensor) begin
                        state_d  = ST_MAIN_Y;
                        load_val = TW'(T_YEL);
                    end
`ifdef TPC_NIGHT_FLASH_EN
                    else if (night) begin
                        state_d = ST_NIGHT;
                    end
`endif
                end
                ST_MAIN_Y: if (expire) begin
                    state_d  = ST_RED_M;
                    load     = 1'b1;
                    load_val = TW'(1);
                end
                ST_RED_M: if (expire) begin
                    load = 1'b1;
                    if (wr) begin
                        state_d  = ST_WALK;
                        load_val = TW'(T_WALK);
                    end else begin
                        state_d  = ST_SIDE_G;
                    end
                end
                ST_WALK: if (expire) begin
                    load    = 1'b1;
                    state_d = sensor ? ST_SIDE_G : ST_MAIN_G;
                end
                ST_SIDE_G: if (expire) begin
                    load = 1'b1;
                    if (sensor && !ext_q) begin
                        ext_d    = 1'b1;
                        load_val = TW'(T_EXT);
                    end else begin
                        ext_d    = 1'b0;
                        state_d  = ST_SIDE_Y;
                        load_val = TW'(T_YEL);
                    end
                end
                ST_SIDE_Y: if (expire) begin
                    state_d  = ST_RED_S;
                    load     = 1'b1;
                    load_val = TW'(1);
                end
                ST_RED_S: if (expire) begin
                    state_d = ST_MAIN_G;
                    load    = 1'b1;
                end
`ifdef TPC_NIGHT_FLASH_EN
                ST_NIGHT: if (!night) begin
                    state_d  = ST_RED_S;
                    load     = 1'b1;
                    load_val = TW'(1);
                end
`endif
                default: begin
                    state_d = ST_MAIN_G;
                    load    = 1'b1;
                end
            endcase
        end
    end

    // Phase state, previous phase and side extension flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MAIN_G;
            prev_q  <= ST_MAIN_G;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= state_q;
            ext_q   <= ext_d;
        end
    end

`ifdef TPC_NIGHT_FLASH_EN
    // Flash phase: lit on NIGHT entry, toggles every tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_q <= 1'b1;
        end else if (state_q != ST_NIGHT) begin
            flash_q <= 1'b1;
        end else if (tick) begin
            flash_q <= ~flash_q;
        end
    end
`endif

    // Lamp decode from the current phase.
    always_comb begin
        main_d = L_RED;
        side_d = L_RED;
        case (state_q)
            ST_MAIN_G: main_d = L_GRN;
            ST_MAIN_Y: main_d = L_YEL;
            ST_SIDE_G: side_d = L_GRN;
            ST_SIDE_Y: side_d = L_YEL;
`ifdef TPC_NIGHT_FLASH_EN
            ST_NIGHT: begin
                main_d = flash_q ? L_YEL : L_OFF;
                side_d = flash_q ? L_RED : L_OFF;
            end
`endif
            default: begin
                main_d = L_RED;
                side_d = L_RED;
            end
        endcase
    end

    // Registered outputs; wr_reset marks the first WALK cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= L_GRN;
            side_q <= L_RED;
            walk_q <= 1'b0;
            wrr_q  <= 1'b0;
        end else begin
            main_q <= main_d;
            side_q <= side_d;
            walk_q <= (state_q == ST_WALK);
            wrr_q  <= (state_q == ST_WALK) && (prev_q != ST_WALK);
        end
    end

    assign main_light = main_q;
    assign side_light = side_q;
    assign walk       = walk_q;
    assign wr_reset   = wrr_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl.
// Cycle-count reference model feeds a scoreboard; fixed checkpoints in a table.
module tb_traffic_phase_ctrl;

    localparam int CLK_DIV = 4;
    localparam int T_BASE  = 6;
    localparam int T_EXT   = 3;
    localparam int T_YEL   = 2;
    localparam int T_WALK  = 3;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       sensor = 1'b0;
    logic       wr     = 1'b0;
`ifdef TPC_NIGHT_FLASH_EN
    logic       night  = 1'b0;
`endif
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       wr_reset;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .CLK_DIV (CLK_DIV),
        .T_BASE  (T_BASE),
        .T_EXT   (T_EXT),
        .T_YEL   (T_YEL),
        .T_WALK  (T_WALK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor     (sensor),
        .wr         (wr),
`ifdef TPC_NIGHT_FLASH_EN
        .night      (night),
`endif
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .wr_reset   (wr_reset)
    );

    typedef struct {
        int         scen;
        int         cyc;
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic       r;
    } vec_t;

    typedef struct {
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic       r;
    } exp_t;

    typedef enum int {MG, MY, RM, WK, SG, SY, RS} ms_t;

    vec_t tab[64];
    int   ntab = 0;
    exp_t sbq[$];
    ms_t  m_st = MG;
    ms_t  m_prev = MG;
    int   m_rem = 0;
    bit   m_ext = 1'b0;
    bit   sb_on = 1'b1;
    int   errors = 0;
    int   checks = 0;

    task automatic add(input int sc, input int cy,
                       input logic [2:0] m, input logic [2:0] s,
                       input logic w, input logic r);
        tab[ntab] = '{sc, cy, m, s, w, r};
        ntab++;
    endtask

    function automatic exp_t m_out();
        exp_t e;
        e.m = 3'b100;
        e.s = 3'b100;
        e.w = 1'b0;
        e.r = 1'b0;
        case (m_st)
            MG: e.m = 3'b001;
            MY: e.m = 3'b010;
            SG: e.s = 3'b001;
            SY: e.s = 3'b010;
            WK: begin
                e.w = 1'b1;
                e.r = (m_prev != WK);
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic go(input ms_t n, input int t);
        m_st  = n;
        m_rem = t * CLK_DIV;
    endtask

    // Reference: phase length counted in raw clock cycles.
    task automatic model_edge(input bit r, input bit s, input bit w);
        exp_t e;
        if (r) begin
            e      = '{3'b001, 3'b100, 1'b0, 1'b0};
            m_st   = MG;
            m_prev = MG;
            m_rem  = T_BASE * CLK_DIV;
            m_ext  = 1'b0;
        end else begin
            e      = m_out();
            m_prev = m_st;
            if (m_rem > 1) begin
                m_rem--;
            end else begin
                case (m_st)
                    MG: if (w || s) go(MY, T_YEL); else go(MG, T_BASE);
                    MY: go(RM, 1);
                    RM: if (w) go(WK, T_WALK); else go(SG, T_BASE);
                    WK: if (s) go(SG, T_BASE); else go(MG, T_BASE);
                    SG: if (s && !m_ext) begin
                        m_rem = T_EXT * CLK_DIV;
                        m_ext = 1'b1;
                    end else begin
                        m_ext = 1'b0;
                        go(SY, T_YEL);
                    end
                    SY: go(RS, 1);
                    default: go(MG, T_BASE);
                endcase
            end
        end
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input int sc, input int cy,
                       input exp_t e);
        checks++;
        if ({main_light, side_light, walk, wr_reset} !==
            {e.m, e.s, e.w, e.r}) begin
            errors++;
            $display("FAIL %s scen=%0d cyc=%0d got m=%b s=%b w=%b r=%b want m=%b s=%b w=%b r=%b",
                     nm, sc, cy, main_light, side_light, walk, wr_reset,
                     e.m, e.s, e.w, e.r);
        end
    endtask

    task automatic run_cycle(input bit r, input bit s, input bit w,
                             input int sc, input int cy);
        exp_t e;
        reset  = r;
        sensor = s;
        wr     = w;
        @(posedge clk);
        model_edge(r, s, w);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty scen=%0d cyc=%0d", sc, cy);
        end else begin
            e = sbq.pop_front();
            if (sb_on) chk("sb", sc, cy, e);
        end
        checks++;
        if (main_light == 3'b001 && side_light == 3'b001) begin
            errors++;
            $display("FAIL both_green scen=%0d cyc=%0d got m=%b s=%b want no double green",
                     sc, cy, main_light, side_light);
        end
        checks++;
        if (walk && (main_light != 3'b100 || side_light != 3'b100)) begin
            errors++;
            $display("FAIL walk_red scen=%0d cyc=%0d got m=%b s=%b want 100/100",
                     sc, cy, main_light, side_light);
        end
        for (int i = 0; i < ntab; i++) begin
            if (tab[i].scen == sc && tab[i].cyc == cy) begin
                e = '{tab[i].m, tab[i].s, tab[i].w, tab[i].r};
                chk("vec", sc, cy, e);
            end
        end
    endtask

    // wr behaves like walk_register: held until wr_reset is seen.
    task automatic run_scen(input int sc, input int n, input int s_on,
                            input int w_on, input int rst_at);
        bit wl;
        bit s;
        bit r;
        wl = 1'b0;
        run_cycle(1'b1, 1'b0, 1'b0, -1, -1);
        run_cycle(1'b1, 1'b0, 1'b0, -1, -1);
        for (int k = 0; k < n; k++) begin
            s = (s_on >= 0) && (k >= s_on);
            if (k == w_on) wl = 1'b1;
            r = (k == rst_at);
`ifdef TPC_NIGHT_FLASH_EN
            night = (sc == 5) && (k < 33);
`endif
            run_cycle(r, s, wl, sc, k);
            if (wr_reset) wl = 1'b0;
        end
    endtask

    initial begin
        // idle
        add(0,   0, 3'b001, 3'b100, 1'b0, 1'b0);
        add(0,  23, 3'b001, 3'b100, 1'b0, 1'b0);
        add(0, 100, 3'b001, 3'b100, 1'b0, 1'b0);
        add(0, 199, 3'b001, 3'b100, 1'b0, 1'b0);
        // sensor only, with one extension
        add(1,  23, 3'b001, 3'b100, 1'b0, 1'b0);
        add(1,  24, 3'b010, 3'b100, 1'b0, 1'b0);
        add(1,  31, 3'b010, 3'b100, 1'b0, 1'b0);
        add(1,  32, 3'b100, 3'b100, 1'b0, 1'b0);
        add(1,  36, 3'b100, 3'b001, 1'b0, 1'b0);
        add(1,  60, 3'b100, 3'b001, 1'b0, 1'b0);
        add(1,  71, 3'b100, 3'b001, 1'b0, 1'b0);
        add(1,  72, 3'b100, 3'b010, 1'b0, 1'b0);
        add(1,  80, 3'b100, 3'b100, 1'b0, 1'b0);
        add(1,  84, 3'b001, 3'b100, 1'b0, 1'b0);
        // walk only
        add(2,  24, 3'b010, 3'b100, 1'b0, 1'b0);
        add(2,  35, 3'b100, 3'b100, 1'b0, 1'b0);
        add(2,  36, 3'b100, 3'b100, 1'b1, 1'b1);
        add(2,  37, 3'b100, 3'b100, 1'b1, 1'b0);
        add(2,  47, 3'b100, 3'b100, 1'b1, 1'b0);
        add(2,  48, 3'b001, 3'b100, 1'b0, 1'b0);
        // walk and sensor together
        add(3,  36, 3'b100, 3'b100, 1'b1, 1'b1);
        add(3,  47, 3'b100, 3'b100, 1'b1, 1'b0);
        add(3,  48, 3'b100, 3'b001, 1'b0, 1'b0);
        // reset during side green
        add(4,  39, 3'b100, 3'b001, 1'b0, 1'b0);
        add(4,  40, 3'b001, 3'b100, 1'b0, 1'b0);
        add(4,  64, 3'b001, 3'b100, 1'b0, 1'b0);
        add(4,  65, 3'b010, 3'b100, 1'b0, 1'b0);
`ifdef TPC_NIGHT_FLASH_EN
        add(5,  24, 3'b010, 3'b100, 1'b0, 1'b0);
        add(5,  27, 3'b010, 3'b100, 1'b0, 1'b0);
        add(5,  28, 3'b000, 3'b000, 1'b0, 1'b0);
        add(5,  32, 3'b010, 3'b100, 1'b0, 1'b0);
        add(5,  36, 3'b100, 3'b100, 1'b0, 1'b0);
        add(5,  40, 3'b001, 3'b100, 1'b0, 1'b0);
`endif

        run_scen(0, 200, -1, -1, -1);
        run_scen(1,  90,  5, -1, -1);
        run_scen(2,  56, -1,  3, -1);
        run_scen(3,  56,  3,  3, -1);
        run_scen(4,  70,  5, -1, 40);
`ifdef TPC_NIGHT_FLASH_EN
        sb_on = 1'b0;
        run_scen(5,  44, -1, -1, -1);
        sb_on = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
